// File: rtl/uart_word_ctrl_pkg.sv
// Shared definitions for the UART word controller: register offsets,
// STATUS bit positions, TX sequencer states and the UART baud constant.
package uart_pkg;

  localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFS_RXDATA = 32'h0000_0004;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0008;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_RX_FULL   = 1;
  localparam int unsigned ST_TX_OVR    = 2;
  localparam int unsigned ST_RX_OVR    = 3;
  localparam int unsigned ST_RX_TMO    = 4;
  localparam int unsigned ST_IRQ_EN_RX = 8;
  localparam int unsigned ST_IRQ_EN_TX = 9;

  // Clock cycles per UART bit, shared with the bit-level core.
  localparam int unsigned DELAY_FRAMES = 234;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/uart_word_ctrl_if.sv
// CPU bus port of the UART word controller.
interface uart_word_ctrl_if;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output write_enable, read_enable, address, data_in,
    input  data_out
  );

  modport slave (
    input  write_enable, read_enable, address, data_in,
    output data_out
  );
endinterface

// File: rtl/uart_word_ctrl_rx_asm.sv
// Receive-side word assembler: collects four bytes MSB-first into RXDATA.
// Optional macro UART_WORD_CTRL_RX_TIMEOUT_EN adds a partial-word timeout.
module uart_rx_word_asm #(
  parameter int unsigned RX_TIMEOUT = 2340
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rd_rxdata,
  input  logic        clr_overrun,
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
  input  logic        clr_timeout,
  output logic        rx_timeout,
`endif
  output logic [31:0] rx_word,
  output logic        rx_full,
  output logic        rx_overrun
);

  if (RX_TIMEOUT == 0) begin : g_bad_timeout
    $error("RX_TIMEOUT must be nonzero");
  end

  logic [31:0] shift_q;
  logic [1:0]  count_q;
  logic        word_done;
  logic [31:0] word_nxt;
  logic        discard;

  assign word_done = rx_valid && (count_q == 2'd3);
  assign word_nxt  = {shift_q[23:0], rx_byte};

`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
  logic [31:0] idle_q;

  assign discard = !rx_valid && (count_q != 2'd0) && (idle_q == RX_TIMEOUT);

  // Idle counter for a partially assembled word, plus sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q     <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (rx_valid || count_q == 2'd0 || discard) idle_q <= '0;
      else                                        idle_q <= idle_q + 32'd1;
      if (discard)          rx_timeout <= 1'b1;
      else if (clr_timeout) rx_timeout <= 1'b0;
    end
  end
`else
  assign discard = 1'b0;
`endif

  // Byte shifting, word hand-off to RXDATA, rx_full and overrun tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      count_q    <= '0;
      rx_word    <= '0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (discard) begin
        shift_q <= '0;
        count_q <= '0;
      end else if (rx_valid) begin
        shift_q <= word_nxt;
        count_q <= count_q + 2'd1;
      end
      // A read in the completion cycle frees the slot, so the new word lands.
      if (word_done && rx_full && !rd_rxdata) begin
        rx_overrun <= 1'b1;
      end else begin
        if (clr_overrun) rx_overrun <= 1'b0;
        if (word_done) begin
          rx_word <= word_nxt;
          rx_full <= 1'b1;
        end else if (rd_rxdata) begin
          rx_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_word_ctrl.sv
// UART word controller: bus register block, TX word sequencer and RX
// word assembly. Optional macro: UART_WORD_CTRL_RX_TIMEOUT_EN.
module uart_word_ctrl
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned RX_TIMEOUT = 2340
) (
  input  logic             clk,
  input  logic             reset,
  uart_word_ctrl_if.slave  bus,
  output logic [7:0]       tx_byte,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic             irq
);

  tx_state_t   state_q, state_nxt;
  logic [31:0] tx_word_q;
  logic [1:0]  idx_q;
  logic        tx_overrun_q;
  logic        irq_en_rx_q, irq_en_tx_q;

  logic        hit_tx, hit_rx, hit_st;
  logic        wr_tx, wr_st, rd_rx;
  logic        tx_empty;
  logic [31:0] rx_word;
  logic        rx_full, rx_overrun, rx_timeout;
  logic [31:0] status;

  assign hit_tx = (bus.address == BASE_ADDR + OFS_TXDATA);
  assign hit_rx = (bus.address == BASE_ADDR + OFS_RXDATA);
  assign hit_st = (bus.address == BASE_ADDR + OFS_STATUS);
  assign wr_tx  = bus.write_enable && hit_tx;
  assign wr_st  = bus.write_enable && hit_st;
  assign rd_rx  = bus.read_enable && hit_rx;

  assign tx_empty = (state_q == TX_IDLE);

  // TX sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= TX_IDLE;
    else       state_q <= state_nxt;
  end

  // TX sequencer next state and start strobe.
  always_comb begin
    state_nxt = state_q;
    tx_start  = 1'b0;
    unique case (state_q)
      TX_IDLE:    if (wr_tx) state_nxt = TX_LOAD;
      TX_LOAD:    state_nxt = TX_START;
      TX_START: begin
        tx_start  = 1'b1;
        state_nxt = TX_WAIT_HI;
      end
      TX_WAIT_HI: if (tx_busy) state_nxt = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) state_nxt = (idx_q == 2'd3) ? TX_IDLE : TX_LOAD;
      default:    state_nxt = TX_IDLE;
    endcase
  end

  // TX datapath: word latch, byte index, byte select and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_word_q    <= '0;
      idx_q        <= '0;
      tx_byte      <= '0;
      tx_overrun_q <= 1'b0;
    end else begin
      if (wr_tx && tx_empty) begin
        tx_word_q <= bus.data_in;
        idx_q     <= '0;
      end
      if (state_q == TX_LOAD)
        tx_byte <= tx_word_q[(5'd31 - {idx_q, 3'b000}) -: 8];
      if (state_q == TX_WAIT_LO && !tx_busy && idx_q != 2'd3)
        idx_q <= idx_q + 2'd1;
      if (wr_tx && !tx_empty)            tx_overrun_q <= 1'b1;
      else if (wr_st && bus.data_in[ST_TX_OVR]) tx_overrun_q <= 1'b0;
    end
  end

  // Interrupt enable bits, written directly through STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_rx_q <= 1'b0;
      irq_en_tx_q <= 1'b0;
    end else if (wr_st) begin
      irq_en_rx_q <= bus.data_in[ST_IRQ_EN_RX];
      irq_en_tx_q <= bus.data_in[ST_IRQ_EN_TX];
    end
  end

  uart_rx_word_asm #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx_asm (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rd_rxdata   (rd_rx),
    .clr_overrun (wr_st && bus.data_in[ST_RX_OVR]),
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
    .clr_timeout (wr_st && bus.data_in[ST_RX_TMO]),
    .rx_timeout  (rx_timeout),
`endif
    .rx_word     (rx_word),
    .rx_full     (rx_full),
    .rx_overrun  (rx_overrun)
  );

`ifndef UART_WORD_CTRL_RX_TIMEOUT_EN
  assign rx_timeout = 1'b0;
`endif

  // STATUS register image.
  always_comb begin
    status               = '0;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_OVR]    = tx_overrun_q;
    status[ST_RX_OVR]    = rx_overrun;
    status[ST_RX_TMO]    = rx_timeout;
    status[ST_IRQ_EN_RX] = irq_en_rx_q;
    status[ST_IRQ_EN_TX] = irq_en_tx_q;
  end

  // Registered read port; zero whenever no decoded read is in progress.
  always_ff @(posedge clk) begin
    if (reset)                             bus.data_out <= '0;
    else if (bus.read_enable && hit_rx)    bus.data_out <= rx_word;
    else if (bus.read_enable && hit_st)    bus.data_out <= status;
    else                                   bus.data_out <= '0;
  end

  assign irq = (rx_full && irq_en_rx_q) || (tx_empty && irq_en_tx_q);

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Directed self-checking bench for uart_word_ctrl.
module tb_uart_word_ctrl;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_TX   = BASE + 32'h0;
  localparam logic [31:0] A_RX   = BASE + 32'h4;
  localparam logic [31:0] A_ST   = BASE + 32'h8;
  localparam int unsigned TMO    = 2340;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       irq;

  int checks = 0;
  int failures = 0;

  uart_word_ctrl_if bus ();

  uart_word_ctrl #(.BASE_ADDR(BASE), .RX_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_byte  (tx_byte),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Busy model: core stays busy for 20 cycles after each start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (reset)          busy_cnt <= 0;
    else if (tx_start)  busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Start-pulse log.
  int         starts = 0;
  logic [7:0] tx_log [64];
  always @(negedge clk) begin
    if (tx_start) begin
      tx_log[starts % 64] <= tx_byte;
      starts <= starts + 1;
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.write_enable = 1'b1;
    bus.address      = a;
    bus.data_in      = d;
    @(negedge clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.read_enable = 1'b1;
    bus.address     = a;
    @(negedge clk);
    bus.read_enable = 1'b0;
    d = bus.data_out;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_done(input int base, input string name);
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (starts == base + 4 && !tx_busy) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: starts=%0d required=%0d", name, starts - base, 4);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(A_ST, v);
    checks++;
    if (v !== exp) begin
      failures++;
      $display("FAIL %s: status=%h required=%h", name, v, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.address      = '0;
    bus.data_in      = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.data_out, tx_byte, tx_start, irq} !== 42'd0) begin
      failures++;
      $display("FAIL reset_outputs: data_out=%h tx_byte=%h tx_start=%b irq=%b required all 0",
               bus.data_out, tx_byte, tx_start, irq);
    end
    reset = 1'b0;
    @(negedge clk);
    check_status("reset_status", 32'h1);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reset_rxdata: got=%h required=%h", v, 32'h0);
    end
  endtask

  task automatic test_tx_word();
    int base;
    logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bus_write(A_ST, 32'h200);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_tx_idle: irq=%b required=1", irq);
    end
    base = starts;
    bus_write(A_TX, 32'hDEAD_BEEF);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_tx_busy: irq=%b required=0", irq);
    end
    check_status("tx_busy_status", 32'h200);
    wait_tx_done(base, "tx_word");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_log[(base + i) % 64] !== exp[i]) begin
        failures++;
        $display("FAIL tx_byte[%0d]: got=%h required=%h", i, tx_log[(base + i) % 64], exp[i]);
      end
    end
    check_status("tx_done_status", 32'h201);
    bus_write(A_ST, 32'h0);
  endtask

  task automatic test_back_to_back();
    int base = starts;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus_write(A_TX, 32'h1122_3344);
    bus_write(A_TX, 32'h5566_7788);
    wait_tx_done(base, "b2b");
    repeat (30) @(negedge clk);
    checks++;
    if (starts !== base + 4) begin
      failures++;
      $display("FAIL b2b_starts: got=%0d required=%0d", starts - base, 4);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_log[(base + i) % 64] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_byte[%0d]: got=%h required=%h", i, tx_log[(base + i) % 64], exp[i]);
      end
    end
    check_status("b2b_overrun", 32'h5);
    bus_write(A_ST, 32'h4);
    check_status("b2b_w1c", 32'h1);
  endtask

  task automatic test_rx_word();
    logic [31:0] v;
    bus_write(A_ST, 32'h100);
    send_rx(8'h12);
    send_rx(8'h34);
    send_rx(8'h56);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_rx_partial: irq=%b required=0", irq);
    end
    send_rx(8'h78);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rx_full: irq=%b required=1", irq);
    end
    check_status("rx_full_set", 32'h103);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rx_word: got=%h required=%h", v, 32'h1234_5678);
    end
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL data_out_idle: got=%h required=0", bus.data_out);
    end
    check_status("rx_full_clr", 32'h101);
    bus_write(A_ST, 32'h0);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] v;
    for (int i = 1; i <= 8; i++) send_rx(8'hA0 + 8'(i));
    check_status("rx_ovr_set", 32'hB);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'hA1A2_A3A4) begin
      failures++;
      $display("FAIL rx_ovr_word: got=%h required=%h", v, 32'hA1A2_A3A4);
    end
    check_status("rx_ovr_after_read", 32'h9);
    bus_write(A_ST, 32'h8);
    check_status("rx_ovr_w1c", 32'h1);
    // Read RXDATA in the same cycle that a second word completes.
    for (int i = 1; i <= 4; i++) send_rx(8'(i));
    for (int i = 5; i <= 7; i++) send_rx(8'(i));
    @(negedge clk);
    rx_valid        = 1'b1;
    rx_byte         = 8'h08;
    bus.read_enable = 1'b1;
    bus.address     = A_RX;
    @(negedge clk);
    rx_valid        = 1'b0;
    bus.read_enable = 1'b0;
    checks++;
    if (bus.data_out !== 32'h0102_0304) begin
      failures++;
      $display("FAIL rx_simul_old: got=%h required=%h", bus.data_out, 32'h0102_0304);
    end
    check_status("rx_simul_status", 32'h3);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'h0506_0708) begin
      failures++;
      $display("FAIL rx_simul_new: got=%h required=%h", v, 32'h0506_0708);
    end
    check_status("rx_simul_clr", 32'h1);
  endtask

  task automatic test_decode();
    logic [31:0] v;
    int base = starts;
    bus_write(BASE + 32'h1, 32'hFFFF_FFFF);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_write(32'h0000_2000, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    checks++;
    if (starts !== base) begin
      failures++;
      $display("FAIL decode_no_tx: starts=%0d required=0", starts - base);
    end
    bus_read(BASE + 32'h9, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL decode_read: got=%h required=0", v);
    end
    check_status("decode_status", 32'h1);
  endtask

  task automatic test_reset_mid_tx();
    int base = starts;
    bit ok = 0;
    bus_write(A_TX, 32'hCAFE_F00D);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (starts == base + 2) begin
        ok = 1;
        break;
      end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reach: starts=%0d busy=%b required 2 and 1", starts - base, tx_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.data_out, tx_byte, tx_start, irq} !== 42'd0) begin
      failures++;
      $display("FAIL mid_reset_out: data_out=%h tx_byte=%h tx_start=%b irq=%b required all 0",
               bus.data_out, tx_byte, tx_start, irq);
    end
    repeat (80) @(negedge clk);
    checks++;
    if (starts !== base + 2) begin
      failures++;
      $display("FAIL mid_no_start: starts=%0d required=2", starts - base);
    end
    checks++;
    if (tx_log[(base + 1) % 64] !== 8'hFE) begin
      failures++;
      $display("FAIL mid_byte2: got=%h required=FE", tx_log[(base + 1) % 64]);
    end
    check_status("mid_status", 32'h1);
  endtask

  task automatic test_rx_partial();
    logic [31:0] v;
    send_rx(8'h99);
    send_rx(8'h98);
    repeat (TMO + 20) @(negedge clk);
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
    check_status("tmo_set", 32'h11);
    bus_write(A_ST, 32'h10);
    check_status("tmo_w1c", 32'h1);
    send_rx(8'hAA);
    send_rx(8'hBB);
    send_rx(8'hCC);
    send_rx(8'hDD);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'hAABB_CCDD) begin
      failures++;
      $display("FAIL tmo_word: got=%h required=%h", v, 32'hAABB_CCDD);
    end
`else
    check_status("partial_wait", 32'h1);
    send_rx(8'h97);
    send_rx(8'h96);
    check_status("partial_full", 32'h3);
    bus_read(A_RX, v);
    checks++;
    if (v !== 32'h9998_9796) begin
      failures++;
      $display("FAIL partial_word: got=%h required=%h", v, 32'h9998_9796);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tx_word();
    test_back_to_back();
    test_rx_word();
    test_rx_overrun();
    test_decode();
    test_reset_mid_tx();
    test_rx_partial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_ctrl.md
Name: uart_word_ctrl

Overview:
Memory-mapped controller that sequences a byte-wide UART TX/RX core for the CPU bus. It accepts 32-bit words from the bus, serializes them MSB-first into four byte transfers on the TX core, and assembles four received bytes into one 32-bit word. It exposes TXDATA, RXDATA and STATUS registers and sits between the bus/memory decoder and the bit-level UART core.

Parameters:
BASE_ADDR, 32'h0000_1000, byte address of register block (TXDATA +0x0, RXDATA +0x4, STATUS +0x8)
RX_TIMEOUT, 2340, idle cycles before a partial RX word is discarded (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
write_enable  in  1  bus write strobe, single cycle
read_enable  in  1  bus read strobe, single cycle
address  in  32  bus byte address
data_in  in  32  bus write data
data_out  out  32  bus read data, registered
tx_byte  out  8  byte to the TX core
tx_start  out  1  one-cycle start pulse to the TX core
tx_busy  in  1  TX core busy
rx_byte  in  8  byte from the RX core
rx_valid  in  1  one-cycle pulse, rx_byte valid
irq  out  1  level: rx_full OR tx_empty when the corresponding enable bit is set

Behaviour:
Reset (clk edge with reset=1): data_out=0, tx_byte=0, tx_start=0, irq=0, TX FSM=IDLE, rx byte count=0, rx_full=0, all sticky bits and irq enables=0. Reset mid-transfer aborts it; no further tx_start follows.
Decode: hit only when address equals BASE_ADDR+offset exactly; other addresses are ignored and reads return 0.
Read: data_out is valid the cycle after read_enable. When read_enable is low, data_out=0.
STATUS[0]=tx_empty (FSM IDLE), [1]=rx_full, [2]=tx_overrun, [3]=rx_overrun, [8]=irq_en_rx, [9]=irq_en_tx. Writing STATUS sets bits 9:8 and clears bit 2 or 3 wherever a 1 is written (W1C).
TX FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO.
- IDLE: a TXDATA write latches the word, sets idx=0 and moves to LOAD.
- LOAD: tx_byte=word[31-8*idx -: 8]; go to START.
- START: tx_start=1 for exactly one cycle; go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0. If idx==3, go to IDLE; otherwise idx++ and go to LOAD.
- A TXDATA write while not IDLE is dropped and sets tx_overrun.
RX assembly:
- On each rx_valid, rx_byte shifts into a 32-bit shift register, MSB first (first byte lands at [31:24]) and the count increments.
- On the 4th byte the word moves to RXDATA, rx_full=1 and the count wraps to 0.
- If rx_full=1 when a word completes, the new word is dropped and rx_overrun is set.
- A read of RXDATA clears rx_full.
- If a RXDATA read and a word completion occur in the same cycle, the read returns the old word, the new word is stored, rx_full stays 1 and there is no overrun.
- A TXDATA write in the same cycle that a TX word finishes (WAIT_LO exit) is treated as busy: overrun.

Optional Feature:
UART_WORD_CTRL_RX_TIMEOUT_EN
- Defined: a cycle counter resets on every rx_valid and runs while the rx count is nonzero. When it reaches RX_TIMEOUT, the partial word is discarded, the count goes to 0 and STATUS[4] (rx_timeout, W1C) is set.
- Undefined: there is no counter, a partial word waits indefinitely, and STATUS[4] reads 0.

Decomposition:
Package uart_pkg: register offsets (TXDATA/RXDATA/STATUS), STATUS bit indices, TX FSM state encoding, DELAY_FRAMES baud constant shared with the UART core.
One natural sub-module, uart_rx_word_asm: shift register, byte count, RXDATA, rx_full, overrun and optional timeout. The TX FSM and bus decode stay in the top level.

Test Plan:
- Write TXDATA=32'hDEADBEEF with a busy-model core (busy 20 cycles after start) -> tx_start pulses 4 times with tx_byte DE, AD, BE, EF in order; STATUS[0] returns to 1 after the last busy falls.
- Write TXDATA twice back-to-back -> second write dropped, STATUS=0x5 after completion; writing STATUS=0x4 clears bit 2.
- rx_valid with bytes 12,34,56,78 then read RXDATA -> data_out=32'h12345678 one cycle later, STATUS[1] goes 1 then 0.
- Receive 8 bytes without reading -> RXDATA holds the first word, STATUS[3]=1; a RXDATA read in the same cycle as the 4th byte -> no overrun.
- Assert reset during WAIT_LO of byte 2 -> all outputs 0, no further tx_start, STATUS reads 0x1.
- With UART_WORD_CTRL_RX_TIMEOUT_EN, send 2 bytes then idle RX_TIMEOUT cycles -> STATUS[4]=1; the next 4 bytes AA,BB,CC,DD give RXDATA=32'hAABBCCDD.
